mem_arbiter_nch: RTL and testbench
==================================

// Module: mem_arbiter_nch
// PURPOSE
//  Parametrised N-channel successor to the two-port memory controller. Arbitrates
//  NUM_CH word requesters (IF, MEM, I-/D-cache refill, ...) onto the byte-serial
//  RAM/IO bus with round-robin grant. Sequences multi-byte reads and writes, and
//  stalls IO writes while the UART buffer is full. Sits between pipeline stages and
//  the cpu top-level mem_* pins.
// PARAMETERS
//  NUM_CH   3   number of requester channels (2..8)
//  MAX_LEN  4   max bytes per transfer; req_len above this is clamped to MAX_LEN
// PORTS
//  clk_in         in   1            system clock
//  rst_in         in   1            asynchronous, active-low reset
//  rdy_in         in   1            low = freeze all state, no RAM write
//  io_buffer_full in   1            UART tx buffer full
//  ram_din        in   8            RAM/IO read byte (valid 1 cycle after its address)
//  ram_dout       out  8            RAM/IO write byte
//  ram_a          out  32           byte address
//  ram_wr         out  1            1 = write this cycle
//  req_valid      in   NUM_CH       per-channel request; held until that channel's done
//  req_wr         in   NUM_CH       per-channel 1 = write
//  req_addr       in   32*NUM_CH    channel c at [32c+31:32c]
//  req_wdata      in   32*NUM_CH    write data, byte0 in [7:0]
//  req_len        in   3*NUM_CH     byte count 0..7
//  done           out  NUM_CH       one-hot 1-cycle completion pulse
//  rdata          out  32           read data, valid while done!=0, byte0 in [7:0]
// BEHAVIOUR
//  - Reset (async, rst_in=0): state IDLE, cnt=0, last_grant=NUM_CH-1; ram_a=0,
//    ram_dout=0, ram_wr=0, done=0, rdata=0. Takes effect mid-transfer, no completion.
//  - rdy_in=0: state, cnt, last_grant, rdata and done hold; ram_wr forced 0.
//  - FSM IDLE/READ/WRITE/DONE. Outputs ram_wr=0, ram_a=0 in IDLE and DONE.
//  - IDLE: if any req_valid, grant the first set channel scanning from
//    last_grant+1 mod NUM_CH upward. Latch addr, wdata, wr, len=min(req_len,MAX_LEN)
//    into working registers; last_grant<=g; cnt<=0.
//    Next state: len==0 -> DONE; wr -> WRITE; else READ.
//  - READ: when cnt<len, ram_a=addr+cnt. When cnt>=1, capture ram_din into byte
//    cnt-1. cnt increments each active cycle. On the cycle cnt==len, capture the last
//    byte and go to DONE. A len-L read spends L+1 cycles in READ.
//  - READ with rdy_in=0 and cnt>=1: ram_a=addr+cnt-1 (combinational re-issue), so
//    ram_din is correct on the resume cycle.
//  - WRITE: ram_a=addr+cnt, ram_dout=wdata byte cnt, ram_wr=1, cnt++.
//    IO stall: if addr[17:16]==2'b11 and io_buffer_full=1, then ram_wr=0 and cnt holds.
//    After byte len-1 is written, go to DONE. A len-L write takes L cycles plus stalls.
//  - DONE (exactly 1 cycle): done[g]=1. rdata holds the assembled bytes, zero above len
//    (0 for writes and len==0). Next state IDLE; the first re-arbitration is the cycle
//    after DONE, so a requester that drops req_valid on seeing done is never re-granted.
//  - Latency from request sampled in IDLE to done high: read L+2 cycles, write L+1
//    cycles, len 0 one cycle. Exactly one transfer is active at a time.
//  - Address arithmetic is 32-bit with wrap; no range checking.
//  - req_* changes on the granted channel after the grant are ignored (latched copy used).
// TESTING
//  1. ch0 read len4 @0x100, RAM=11 22 33 44 -> ram_a 0x100..0x103 on consecutive
//     cycles; done[0] 6 cycles after request; rdata=0x44332211.
//  2. All 3 channels held, len1 reads -> grant order 0,1,2,0.
//     Each done one-hot; no channel granted twice in a row while others wait.
//  3. ch1 write len1 @0x30000 data 0x41, io_buffer_full=1 for 3 cycles -> ram_wr=0
//     for 3 cycles, then one cycle ram_wr=1, ram_dout=0x41; then done[1].
//  4. Read len4 with rdy_in=0 for 2 cycles at cnt=2 -> rdata still 0x44332211.
//     done delayed exactly 2 cycles; ram_wr stays 0.
//  5. rst_in=0 mid-way through a len4 write -> ram_wr/ram_a/done go 0 immediately.
//     After release, simultaneous ch0/ch2 requests -> ch0 granted first.
//  6. MAX_LEN=4: req_len=7 -> exactly 4 bytes transferred.
//     req_len=0 -> no ram access, done next cycle, rdata=0.

Source files
------------

// File: rtl/mem_arbiter_nch.sv
// Round-robin arbiter of NUM_CH word requesters onto a byte-serial RAM/IO bus.
// One transfer runs at a time; reads and writes are sequenced one byte per cycle.
module mem_arbiter_nch #(
    parameter int NUM_CH  = 3,
    parameter int MAX_LEN = 4
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  io_buffer_full,
    input  logic [7:0]            ram_din,
    output logic [7:0]            ram_dout,
    output logic [31:0]           ram_a,
    output logic                  ram_wr,
    input  logic [NUM_CH-1:0]     req_valid,
    input  logic [NUM_CH-1:0]     req_wr,
    input  logic [32*NUM_CH-1:0]  req_addr,
    input  logic [32*NUM_CH-1:0]  req_wdata,
    input  logic [3*NUM_CH-1:0]   req_len,
    output logic [NUM_CH-1:0]     done,
    output logic [31:0]           rdata
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t          state_q;
    logic [CH_W-1:0] last_grant_q;
    logic [2:0]      cnt_q;
    logic [2:0]      len_q;
    logic [31:0]     addr_q;
    logic [31:0]     wdata_q;
    logic [31:0]     rdata_q;
    logic            wr_q;

    logic            gnt_found;
    logic [CH_W-1:0] gnt_idx;
    logic [CH_W-1:0] scan_idx;
    logic [2:0]      gnt_len_raw;
    logic [2:0]      gnt_len;
    logic            io_stall;

    // Round-robin: first requester strictly after the last grant wins.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        gnt_found = 1'b0;
        gnt_idx   = '0;
        scan_idx  = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            scan_idx = CH_W'((int'(last_grant_q) + i) % NUM_CH);
            if (!gnt_found && req_valid[scan_idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = scan_idx;
            end
        end
    end

    assign gnt_len_raw = req_len[3*gnt_idx +: 3];
    assign gnt_len     = (gnt_len_raw > 3'(MAX_LEN)) ? 3'(MAX_LEN) : gnt_len_raw;
    assign io_stall    = (addr_q[17:16] == 2'b11) && io_buffer_full;
    assign rdata       = rdata_q;

    always_comb begin
        ram_a    = '0;
        ram_dout = '0;
        ram_wr   = 1'b0;
        done     = '0;
        unique case (state_q)
            READ: begin
                // While frozen, keep the previous byte's address on the bus so
                // ram_din still carries it when the pipeline resumes.
                if (!rdy_in && cnt_q != 3'd0)
                    ram_a = addr_q + 32'(cnt_q) - 32'd1;
                else if (cnt_q < len_q)
                    ram_a = addr_q + 32'(cnt_q);
            end
            WRITE: begin
                ram_a    = addr_q + 32'(cnt_q);
                ram_dout = 8'(wdata_q >> (8 * cnt_q));
                ram_wr   = rdy_in && !io_stall;
            end
            DONE:    done[last_grant_q] = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        // NOTE: state uses non-blocking assignments so every register sees pre-edge values.
        if (!rst_in) begin
            state_q      <= IDLE;
            last_grant_q <= CH_W'(NUM_CH - 1);
            cnt_q        <= '0;
            len_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            wr_q         <= 1'b0;
        end else if (rdy_in) begin
            unique case (state_q)
                IDLE: begin
                    if (gnt_found) begin
                        last_grant_q <= gnt_idx;
                        addr_q       <= req_addr[32*gnt_idx +: 32];
                        wdata_q      <= req_wdata[32*gnt_idx +: 32];
                        wr_q         <= req_wr[gnt_idx];
                        len_q        <= gnt_len;
                        cnt_q        <= '0;
                        rdata_q      <= '0;
                        if (gnt_len == 3'd0)
                            state_q <= DONE;
                        else if (req_wr[gnt_idx])
                            state_q <= WRITE;
                        else
                            state_q <= READ;
                    end
                end
                READ: begin
                    if (cnt_q != 3'd0)
                        rdata_q <= rdata_q | (32'(ram_din) << (8 * (cnt_q - 3'd1)));
                    if (cnt_q == len_q)
                        state_q <= DONE;
                    else
                        cnt_q <= cnt_q + 3'd1;
                end
                WRITE: begin
                    if (!io_stall) begin
                        if (cnt_q == len_q - 3'd1)
                            state_q <= DONE;
                        else
                            cnt_q <= cnt_q + 3'd1;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter_nch.sv
// Randomised bench for mem_arbiter_nch: a phase-level reference model with a shadow
// memory, and a byte-wide RAM/IO model attached to the bus.
module tb_mem_arbiter_nch;
    localparam int NCH  = 3;
    localparam int MAXL = 4;

    typedef enum {PH_IDLE, PH_BODY, PH_DONE} phase_t;

    logic              clk_in;
    logic              rst_in;
    logic              rdy_in;
    logic              io_buffer_full;
    logic [7:0]        ram_din;
    logic [7:0]        ram_dout;
    logic [31:0]       ram_a;
    logic              ram_wr;
    logic [NCH-1:0]    req_valid;
    logic [NCH-1:0]    req_wr;
    logic [32*NCH-1:0] req_addr;
    logic [32*NCH-1:0] req_wdata;
    logic [3*NCH-1:0]  req_len;
    logic [NCH-1:0]    done;
    logic [31:0]       rdata;

    mem_arbiter_nch #(.NUM_CH(NCH), .MAX_LEN(MAXL)) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .io_buffer_full (io_buffer_full),
        .ram_din        (ram_din),
        .ram_dout       (ram_dout),
        .ram_a          (ram_a),
        .ram_wr         (ram_wr),
        .req_valid      (req_valid),
        .req_wr         (req_wr),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_len        (req_len),
        .done           (done),
        .rdata          (rdata)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] ch_addr  [NCH];
    logic [31:0] ch_wdata [NCH];
    logic [2:0]  ch_len   [NCH];

    logic [7:0] tb_ram [logic [31:0]];
    logic [7:0] shadow [logic [31:0]];

    phase_t         m_phase;
    int             m_ch, m_last, m_len, m_left;
    logic           m_wr;
    logic [31:0]    m_addr, m_wdata, m_rdata;
    logic [NCH-1:0] drop_mask;
    bit             rand_mode;

    logic [31:0]    s_a;
    logic           s_wr;
    logic [7:0]     s_dout;
    logic [NCH-1:0] first_done;
    bit             seen_first;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        if (tb_ram.exists(a)) return tb_ram[a];
        return init_byte(a);
    endfunction

    function automatic logic [7:0] shadow_rd(input logic [31:0] a);
        if (shadow.exists(a)) return shadow[a];
        return init_byte(a);
    endfunction

    function automatic bit stall_now();
        return m_wr && (m_addr[17:16] == 2'b11) && io_buffer_full;
    endfunction

    task automatic model_reset();
        m_phase   = PH_IDLE;
        m_last    = NCH - 1;
        m_ch      = 0;
        m_len     = 0;
        m_left    = 0;
        m_wr      = 1'b0;
        m_addr    = '0;
        m_wdata   = '0;
        m_rdata   = '0;
        drop_mask = '0;
    endtask

    task automatic pack_reqs();
        for (int c = 0; c < NCH; c++) begin
            req_addr[32*c +: 32]  = ch_addr[c];
            req_wdata[32*c +: 32] = ch_wdata[c];
            req_len[3*c +: 3]     = ch_len[c];
        end
    endtask

    task automatic new_req(input int c);
        logic [31:0] base;
        case ($urandom_range(0, 2))
            0:       base = 32'h0000_0100;
            1:       base = 32'h0003_0010;
            default: base = 32'hFFFF_FFFC;
        endcase
        ch_addr[c]  = base + 32'($urandom_range(0, 7));
        ch_wdata[c] = $urandom;
        ch_len[c]   = 3'($urandom_range(0, 7));
        req_wr[c]   = 1'($urandom_range(0, 1));
    endtask

    // Compare this cycle's outputs with the model, then advance the model across the edge.
    task automatic check_cycle();
        logic [NCH-1:0] exp_done;
        logic [NCH-1:0] rv;
        logic           exp_wr;
        int             idx, g;
        bit             found;
        exp_done = '0;
        if (m_phase == PH_DONE) exp_done = NCH'(1) << m_ch;
        check("done", 32'(done), 32'(exp_done));
        if (m_phase == PH_DONE) check("rdata", rdata, m_rdata);
        if (m_phase != PH_BODY) check("ram_a_quiet", ram_a, 32'd0);
        idx    = m_len - m_left;
        exp_wr = (m_phase == PH_BODY) && m_wr && rdy_in && !stall_now();
        check("ram_wr", 32'(ram_wr), 32'(exp_wr));
        if (exp_wr) begin
            check("wr_addr", ram_a, m_addr + 32'(idx));
            check("wr_byte", 32'(ram_dout), 32'(8'(m_wdata >> (8 * idx))));
        end
        if (done != '0 && !seen_first) begin
            seen_first = 1'b1;
            first_done = done;
        end
        if (rdy_in) begin
            case (m_phase)
                PH_IDLE: begin
                    found = 1'b0;
                    g     = 0;
                    for (int i = 1; i <= NCH; i++) begin
                        rv = req_valid >> ((m_last + i) % NCH);
                        if (!found && rv[0]) begin
                            found = 1'b1;
                            g     = (m_last + i) % NCH;
                        end
                    end
                    if (found) begin
                        rv      = req_wr >> g;
                        m_ch    = g;
                        m_last  = g;
                        m_addr  = ch_addr[g];
                        m_wdata = ch_wdata[g];
                        m_wr    = rv[0];
                        m_len   = (int'(ch_len[g]) > MAXL) ? MAXL : int'(ch_len[g]);
                        m_rdata = '0;
                        if (m_len == 0) begin
                            m_phase = PH_DONE;
                        end else if (m_wr) begin
                            m_phase = PH_BODY;
                            m_left  = m_len;
                        end else begin
                            m_phase = PH_BODY;
                            m_left  = m_len + 1;
                            for (int i = 0; i < m_len; i++)
                                m_rdata = m_rdata | (32'(shadow_rd(m_addr + 32'(i))) << (8 * i));
                        end
                    end
                end
                PH_BODY: begin
                    if (!(m_wr && stall_now())) begin
                        if (m_wr) shadow[m_addr + 32'(idx)] = 8'(m_wdata >> (8 * idx));
                        m_left--;
                    end
                    if (m_left == 0) m_phase = PH_DONE;
                end
                default: begin
                    m_phase   = PH_IDLE;
                    drop_mask = drop_mask | (NCH'(1) << m_ch);
                end
            endcase
        end
    endtask

    task automatic drive_inputs();
        logic [NCH-1:0] fresh_drop;
        fresh_drop = drop_mask;
        req_valid  = req_valid & ~drop_mask;
        drop_mask  = '0;
        if (rand_mode) begin
            rdy_in         = ($urandom_range(0, 7) != 0);
            io_buffer_full = ($urandom_range(0, 2) == 0);
            for (int c = 0; c < NCH; c++) begin
                if (!req_valid[c] && !fresh_drop[c] && $urandom_range(0, 2) == 0) begin
                    new_req(c);
                    req_valid[c] = 1'b1;
                end else if (req_valid[c] && m_phase != PH_IDLE && m_ch == c
                             && $urandom_range(0, 3) == 0) begin
                    new_req(c);
                end
            end
        end else begin
            rdy_in         = 1'b1;
            io_buffer_full = 1'b0;
        end
        pack_reqs();
    endtask

    task automatic step();
        @(negedge clk_in);
        s_a    = ram_a;
        s_wr   = ram_wr;
        s_dout = ram_dout;
        check_cycle();
        @(posedge clk_in);
        #1;
        if (s_wr) tb_ram[s_a] = s_dout;
        ram_din = ram_rd(s_a);
        drive_inputs();
    endtask

    initial begin
        rst_in         = 1'b0;
        rdy_in         = 1'b1;
        io_buffer_full = 1'b0;
        ram_din        = '0;
        req_valid      = '0;
        req_wr         = '0;
        for (int c = 0; c < NCH; c++) begin
            ch_addr[c]  = '0;
            ch_wdata[c] = '0;
            ch_len[c]   = '0;
        end
        pack_reqs();
        rand_mode  = 1'b0;
        seen_first = 1'b0;
        first_done = '0;
        model_reset();

        #3;
        check("rst_done", 32'(done), 32'd0);
        check("rst_ram_wr", 32'(ram_wr), 32'd0);
        check("rst_ram_a", ram_a, 32'd0);
        check("rst_ram_dout", 32'(ram_dout), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        #5 rst_in = 1'b1;

        rand_mode = 1'b1;
        repeat (3000) step();
        rand_mode = 1'b0;
        for (int k = 0; k < 200 && !(req_valid == '0 && m_phase == PH_IDLE); k++) step();

        // Reset in the middle of a 4-byte write.
        ch_addr[0]  = 32'h0000_0200;
        ch_wdata[0] = 32'hA1B2_C3D4;
        ch_len[0]   = 3'd4;
        req_wr[0]   = 1'b1;
        req_valid[0] = 1'b1;
        pack_reqs();
        for (int k = 0; k < 20 && !(m_phase == PH_BODY && m_left == 2); k++) step();
        check("pre_rst_wr", 32'(ram_wr), 32'd1);
        #1 rst_in = 1'b0;
        model_reset();
        req_valid = '0;
        req_wr    = '0;
        pack_reqs();
        #1;
        check("mid_rst_wr", 32'(ram_wr), 32'd0);
        check("mid_rst_a", ram_a, 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        #1 rst_in = 1'b1;

        // Simultaneous ch0/ch2 requests right after reset: ch0 must win.
        ch_addr[0] = 32'h0000_0100;
        ch_len[0]  = 3'd1;
        ch_addr[2] = 32'h0003_0011;
        ch_len[2]  = 3'd1;
        req_valid  = NCH'(5);
        pack_reqs();
        seen_first = 1'b0;
        first_done = '0;
        for (int k = 0; k < 40 && !(req_valid == '0 && m_phase == PH_IDLE); k++) step();
        check("first_after_rst", 32'(first_done), 32'd1);

        foreach (shadow[a]) check("mem", 32'(ram_rd(a)), 32'(shadow[a]));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
